// File: rtl/decode_alu_mem.sv
// ---------------------------------------------------------------------------
// decode_alu_mem
//   Single-cycle MIPS-style execute slice: instruction decoder, 32-bit ALU
//   and a word-addressed data memory. Only the memory write is clocked.
//
// Parameters
//   DEPTH  number of 32-bit data-memory words (power of two)
//   AW     word-address width, log2(DEPTH)
//
// Ports
//   clk, rst             clock; async active-high reset (clears memory)
//   instruction          instruction word
//   reg_rs, reg_rt       register file read values
//   opcode..adr          raw instruction fields
//   regwrite, memwrite,
//   memread, imm_reg     control flags
//   alu_op               ALU operation code
//   alu_result, zero     ALU result (also memory byte address), zero flag
//   read_data            memory word at alu_result
//   write_data           write-back value (memory data or ALU result)
//   mem_err              only with MEM_BOUNDS_CHECK_EN: out-of-range or
//                        misaligned access; the access is then squashed
//
// Build option: define MEM_BOUNDS_CHECK_EN to add bounds/alignment checking.
// ---------------------------------------------------------------------------
module decode_alu_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] reg_rs,
    input  logic [31:0] reg_rt,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] adr,
    output logic        regwrite,
    output logic        memwrite,
    output logic        memread,
    output logic [3:0]  alu_op,
    output logic        imm_reg,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] read_data,
    output logic [31:0] write_data
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic        mem_err
`endif
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;

    // ---------------- field split ----------------
    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign shamt  = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm    = instruction[15:0];
    assign adr    = instruction[25:0];

    // ---------------- control generation ----------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front,
        // so no decode path can leave one unassigned and infer a latch.
        regwrite = 1'b0;
        memwrite = 1'b0;
        memread  = 1'b0;
        imm_reg  = 1'b0;
        alu_op   = ALU_ADD;
        case (opcode)
            6'h00: begin
                regwrite = 1'b1;
                case (funct)
                    6'h20:   alu_op = ALU_ADD;
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h26:   alu_op = ALU_XOR;
                    6'h27:   alu_op = ALU_NOR;
                    6'h2A:   alu_op = ALU_SLT;
                    6'h00:   alu_op = ALU_SLL;
                    6'h02:   alu_op = ALU_SRL;
                    6'h03:   alu_op = ALU_SRA;
                    default: regwrite = 1'b0;   // unsupported funct: no write-back
                endcase
            end
            6'h08: begin regwrite = 1'b1; imm_reg = 1'b1; alu_op = ALU_ADD; end
            6'h0A: begin regwrite = 1'b1; imm_reg = 1'b1; alu_op = ALU_SLT; end
            6'h0C: begin regwrite = 1'b1; imm_reg = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin regwrite = 1'b1; imm_reg = 1'b1; alu_op = ALU_OR;  end
            6'h0E: begin regwrite = 1'b1; imm_reg = 1'b1; alu_op = ALU_XOR; end
            6'h0F: begin regwrite = 1'b1; imm_reg = 1'b1; alu_op = ALU_LUI; end
            6'h23: begin regwrite = 1'b1; imm_reg = 1'b1; memread = 1'b1; end
            6'h2B: begin memwrite = 1'b1; imm_reg = 1'b1; end
            6'h04, 6'h05: alu_op = ALU_SUB;     // branch compare, zero is the condition
            default: ;                          // jumps and unknown opcodes: inert
        endcase
    end

    // ---------------- ALU ----------------
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign op_a = reg_rs;
    // Immediate is always sign-extended, even for the logical ops.
    assign op_b = imm_reg ? {{16{imm[15]}}, imm} : reg_rt;

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_XOR: alu_result = op_a ^ op_b;
            ALU_NOR: alu_result = ~(op_a | op_b);
            ALU_SLT: alu_result = {31'h0, $signed(op_a) < $signed(op_b)};
            ALU_SLL: alu_result = op_b << shamt;
            ALU_SRL: alu_result = op_b >> shamt;
            ALU_SRA: alu_result = $unsigned($signed(op_b) >>> shamt);
            ALU_LUI: alu_result = {op_b[15:0], 16'h0};
            default: alu_result = 32'h0;
        endcase
    end

    assign zero = (alu_result == 32'h0);

    // ---------------- data memory ----------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] mem_idx;
    logic          wr_en;

    // Byte offset and bits above the array are dropped: addresses wrap.
    assign mem_idx = alu_result[AW+1:2];

`ifdef MEM_BOUNDS_CHECK_EN
    logic addr_bad;
    assign addr_bad  = (alu_result[31:AW+2] != '0) || (alu_result[1:0] != 2'b00);
    assign mem_err   = (memread || memwrite) && addr_bad;
    assign wr_en     = memwrite && !mem_err;
    assign read_data = mem_err ? 32'h0 : mem[mem_idx];
`else
    assign wr_en     = memwrite;
    assign read_data = mem[mem_idx];
`endif

    // NOTE: the whole array is cleared asynchronously, so it maps to flops
    // rather than a RAM macro; that is the price of a one-shot memory reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (wr_en) begin
            // NOTE: clocked state uses non-blocking assignment so every reader
            // in the same edge sees the pre-edge value.
            mem[mem_idx] <= reg_rt;
        end
    end

    assign write_data = memread ? read_data : alu_result;

endmodule

// File: tb/tb_decode_alu_mem.sv
// ---------------------------------------------------------------------------
// tb_decode_alu_mem
//   Self-checking bench for decode_alu_mem. A mnemonic-level model predicts
//   every output each cycle; directed vectors carry hand-computed literals.
//   Define MEM_BOUNDS_CHECK_EN here as well to check the bounds option.
// ---------------------------------------------------------------------------
module tb_decode_alu_mem;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] reg_rs;
    logic [31:0] reg_rt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] adr;
    logic        regwrite;
    logic        memwrite;
    logic        memread;
    logic [3:0]  alu_op;
    logic        imm_reg;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] read_data;
    logic [31:0] write_data;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        mem_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    decode_alu_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .reg_rs(reg_rs), .reg_rt(reg_rt),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .adr(adr),
        .regwrite(regwrite), .memwrite(memwrite), .memread(memread),
        .alu_op(alu_op), .imm_reg(imm_reg),
        .alu_result(alu_result), .zero(zero),
        .read_data(read_data), .write_data(write_data)
`ifdef MEM_BOUNDS_CHECK_EN
        , .mem_err(mem_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        mr;
        logic        ir;
        logic [3:0]  op;
        logic [31:0] res;
    } exp_t;

    function automatic exp_t mk(input logic rw, input logic mw, input logic mr,
                                input logic ir, input logic [3:0] op, input logic [31:0] res);
        exp_t e;
        e.rw = rw; e.mw = mw; e.mr = mr; e.ir = ir; e.op = op; e.res = res;
        return e;
    endfunction

    function automatic logic [31:0] slt(input logic [31:0] x, input logic [31:0] y);
        return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endfunction

    // Outcome of one instruction, straight from the mnemonic tables.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] si;
        logic [4:0]  sh;
        si = {{16{ins[15]}}, ins[15:0]};
        sh = ins[10:6];
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20:   return mk(1, 0, 0, 0, 4'd0, a + b);
                6'h22:   return mk(1, 0, 0, 0, 4'd1, a - b);
                6'h24:   return mk(1, 0, 0, 0, 4'd2, a & b);
                6'h25:   return mk(1, 0, 0, 0, 4'd3, a | b);
                6'h26:   return mk(1, 0, 0, 0, 4'd4, a ^ b);
                6'h27:   return mk(1, 0, 0, 0, 4'd5, ~(a | b));
                6'h2A:   return mk(1, 0, 0, 0, 4'd6, slt(a, b));
                6'h00:   return mk(1, 0, 0, 0, 4'd7, b << sh);
                6'h02:   return mk(1, 0, 0, 0, 4'd8, b >> sh);
                6'h03:   return mk(1, 0, 0, 0, 4'd9, $unsigned($signed(b) >>> sh));
                default: return mk(0, 0, 0, 0, 4'd0, a + b);
            endcase
            6'h08:   return mk(1, 0, 0, 1, 4'd0,  a + si);
            6'h0A:   return mk(1, 0, 0, 1, 4'd6,  slt(a, si));
            6'h0C:   return mk(1, 0, 0, 1, 4'd2,  a & si);
            6'h0D:   return mk(1, 0, 0, 1, 4'd3,  a | si);
            6'h0E:   return mk(1, 0, 0, 1, 4'd4,  a ^ si);
            6'h0F:   return mk(1, 0, 0, 1, 4'd10, {ins[15:0], 16'h0});
            6'h23:   return mk(1, 0, 1, 1, 4'd0,  a + si);
            6'h2B:   return mk(0, 1, 0, 1, 4'd0,  a + si);
            6'h04, 6'h05: return mk(0, 0, 0, 0, 4'd1, a - b);
            default: return mk(0, 0, 0, 0, 4'd0,  a + b);
        endcase
    endfunction

    function automatic logic addr_bad(input exp_t e);
`ifdef MEM_BOUNDS_CHECK_EN
        return (e.mr || e.mw) && ((e.res >= 32'(4 * DEPTH)) || (e.res % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    logic [31:0] mmem [DEPTH];

    always @(posedge clk or posedge rst) begin
        exp_t e;
        e = model(instruction, reg_rs, reg_rt);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
        end else if (e.mw && !addr_bad(e)) begin
            mmem[(e.res / 4) % DEPTH] = reg_rt;
        end
    end

    // Compare process: every output, every cycle, away from the active edge.
    initial begin
        exp_t        e;
        logic        bad;
        logic [31:0] rd_exp;
        forever begin
            @(negedge clk);
            e      = model(instruction, reg_rs, reg_rt);
            bad    = addr_bad(e);
            rd_exp = bad ? 32'h0 : mmem[(e.res / 4) % DEPTH];
            check("fields",     {opcode, rs, rt, rd, shamt, funct}, instruction);
            check("imm",        {16'h0, imm}, {16'h0, instruction[15:0]});
            check("adr",        {6'h0, adr}, {6'h0, instruction[25:0]});
            check("ctrl",       {28'h0, regwrite, memwrite, memread, imm_reg},
                                {28'h0, e.rw, e.mw, e.mr, e.ir});
            check("alu_op",     {28'h0, alu_op}, {28'h0, e.op});
            check("alu_result", alu_result, e.res);
            check("zero",       {31'h0, zero}, {31'h0, e.res == 32'h0});
            check("read_data",  read_data, rd_exp);
            check("write_data", write_data, e.mr ? rd_exp : e.res);
`ifdef MEM_BOUNDS_CHECK_EN
            check("mem_err",    {31'h0, mem_err}, {31'h0, bad});
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] i);
        return {op, s, t, i};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    // Apply a vector just after a rising edge; return on the next falling edge.
    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        instruction = ins;
        reg_rs      = a;
        reg_rt      = b;
        @(negedge clk);
    endtask

    task automatic alu_case(input string name, input logic [31:0] ins,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(ins, a, b);
        check(name, alu_result, exp);
    endtask

    initial begin
        rst         = 1'b0;
        instruction = 32'h0;
        reg_rs      = 32'h0;
        reg_rt      = 32'h0;
        #1 rst = 1'b1;

        // Reset state: memory reads zero.
        @(negedge clk);
        instruction = itype(6'h23, 5'd0, 5'd1, 16'd0);
        #1;
        check("reset_read", read_data, 32'h0);
        #2 rst = 1'b0;

        // R-type field split and decode.
        drive(32'h000A5B22, 32'h0, 32'h0);
        check("rt_opcode", {26'h0, opcode}, 32'd0);
        check("rt_rs",     {27'h0, rs},     32'd0);
        check("rt_rt",     {27'h0, rt},     32'd10);
        check("rt_rd",     {27'h0, rd},     32'd11);
        check("rt_shamt",  {27'h0, shamt},  32'd12);
        check("rt_funct",  {26'h0, funct},  32'h22);
        check("rt_ctrl",   {28'h0, regwrite, memwrite, memread, imm_reg}, 32'b1000);
        check("rt_alu_op", {28'h0, alu_op}, 32'd1);

        // addi with negative immediate.
        drive(itype(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd5, 32'h0);
        check("addi_res",  alu_result, 32'd4);
        check("addi_wb",   write_data, 32'd4);
        check("addi_zero", {31'h0, zero}, 32'd0);

        // sw then lw at the same address.
        drive(itype(6'h2B, 5'd0, 5'd1, 16'd8), 32'h0, 32'hDEADBEEF);
        drive(itype(6'h23, 5'd0, 5'd1, 16'd8), 32'h0, 32'h0);
        check("lw_read", read_data,  32'hDEADBEEF);
        check("lw_wb",   write_data, 32'hDEADBEEF);

        // beq with equal operands, signed slt.
        drive(itype(6'h04, 5'd1, 5'd2, 16'd3), 32'd7, 32'd7);
        check("beq_zero", {31'h0, zero}, 32'd1);
        check("beq_en",   {30'h0, regwrite, memwrite}, 32'd0);
        alu_case("slt_neg", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1, 32'd1);

        // ALU coverage.
        alu_case("sub",     rtype(1, 2, 3, 0, 6'h22), 32'd3, 32'd5, 32'hFFFFFFFE);
        alu_case("add_wrap",rtype(1, 2, 3, 0, 6'h20), 32'hFFFFFFFF, 32'd2, 32'd1);
        alu_case("and",     rtype(1, 2, 3, 0, 6'h24), 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        alu_case("or",      rtype(1, 2, 3, 0, 6'h25), 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF);
        alu_case("xor",     rtype(1, 2, 3, 0, 6'h26), 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00);
        alu_case("nor",     rtype(1, 2, 3, 0, 6'h27), 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F);
        alu_case("sll",     rtype(1, 2, 3, 31, 6'h00), 32'h0, 32'd1, 32'h80000000);
        alu_case("srl",     rtype(1, 2, 3, 4, 6'h02), 32'h0, 32'h80000000, 32'h08000000);
        alu_case("sra",     rtype(1, 2, 3, 4, 6'h03), 32'h0, 32'h80000000, 32'hF8000000);
        alu_case("lui",     itype(6'h0F, 0, 1, 16'h1234), 32'hDEADBEEF, 32'h0, 32'h12340000);
        alu_case("andi_sx", itype(6'h0C, 1, 2, 16'h8000), 32'h12348765, 32'h0, 32'h12348000);
        alu_case("ori",     itype(6'h0D, 1, 2, 16'h00F0), 32'h00000F00, 32'h0, 32'h00000FF0);
        alu_case("xori_sx", itype(6'h0E, 1, 2, 16'hFFFF), 32'h0000FFFF, 32'h0, 32'hFFFF0000);
        alu_case("slti_t",  itype(6'h0A, 1, 2, 16'hFFFE), 32'hFFFFFFFB, 32'h0, 32'd1);
        alu_case("slti_f",  itype(6'h0A, 1, 2, 16'd2), 32'd3, 32'h0, 32'd0);
        alu_case("bne",     itype(6'h05, 1, 2, 16'd0), 32'd1, 32'd2, 32'hFFFFFFFF);
        alu_case("bad_fn",  rtype(1, 2, 3, 0, 6'h3F), 32'd2, 32'd3, 32'd5);
        check("bad_fn_rw", {31'h0, regwrite}, 32'd0);

        // Unknown opcode and jump: all enables off.
        drive(itype(6'h3F, 5'd1, 5'd2, 16'd4), 32'h10, 32'h20);
        check("unk_en", {28'h0, regwrite, memwrite, memread, imm_reg}, 32'd0);
        drive({6'h02, 26'h0000123}, 32'h10, 32'h20);
        check("j_en",   {28'h0, regwrite, memwrite, memread, imm_reg}, 32'd0);

        // Asynchronous reset clears memory and blocks writes.
        drive(itype(6'h2B, 5'd0, 5'd1, 16'd8), 32'h0, 32'h55AA55AA);
        drive(itype(6'h23, 5'd0, 5'd1, 16'd8), 32'h0, 32'h0);
        check("pre_rst", read_data, 32'h55AA55AA);
        #2 rst = 1'b1;
        #1;
        check("async_clr", read_data, 32'h0);
        instruction = itype(6'h2B, 5'd0, 5'd1, 16'd8);
        reg_rt      = 32'h11111111;
        @(posedge clk);
        #1;
        check("rst_blocks_wr", read_data, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_wr", read_data, 32'h11111111);

        // Address 4*DEPTH+8 aliases word 2 unless bounds checking is on.
        drive(itype(6'h2B, 5'd1, 5'd2, 16'd8), 32'd256, 32'h12345678);
`ifdef MEM_BOUNDS_CHECK_EN
        check("alias_err", {31'h0, mem_err}, 32'd1);
`else
        check("alias_addr", alu_result, 32'd264);
`endif
        drive(itype(6'h23, 5'd0, 5'd1, 16'd8), 32'h0, 32'h0);
`ifdef MEM_BOUNDS_CHECK_EN
        check("alias_rd", read_data, 32'h11111111);
`else
        check("alias_rd", read_data, 32'h12345678);
`endif

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_alu_mem.md
Name: decode_alu_mem

Overview:
- Single-cycle MIPS-style execute slice with three parts:
  - instruction decoder: field split plus control generation
  - 32-bit ALU
  - word-addressed data memory
- Sits between the register file and write-back. Takes the fetched instruction and the two register read values; returns decoded fields, control flags, ALU result/zero and write-back data.
- Only the memory write is clocked; everything else is combinational.

Parameters:
- DEPTH, 64, number of 32-bit data-memory words (power of two).
- AW, 6, word-address width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; memory writes on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all memory words to 0.
- instruction  in  32  instruction word.
- reg_rs  in  32  register value selected by rs.
- reg_rt  in  32  register value selected by rt.
- opcode  out  6  instruction[31:26].
- rs  out  5  instruction[25:21].
- rt  out  5  instruction[20:16].
- rd  out  5  instruction[15:11].
- shamt  out  5  instruction[10:6].
- funct  out  6  instruction[5:0].
- imm  out  16  instruction[15:0].
- adr  out  26  instruction[25:0].
- regwrite  out  1  register write enable.
- memwrite  out  1  data-memory write enable.
- memread  out  1  selects memory data for write-back.
- alu_op  out  4  ALU operation code.
- imm_reg  out  1  ALU operand B is the immediate.
- alu_result  out  32  ALU result, also the memory byte address.
- zero  out  1  high when alu_result == 0.
- read_data  out  32  memory word at alu_result.
- write_data  out  32  memread ? read_data : alu_result.

Behaviour:
- Field outputs are pure bit slices of instruction, always valid, independent of opcode.
- alu_op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed; result 1 or 0)
  - 7 SLL, 8 SRL, 9 SRA: B shifted by shamt
  - 10 LUI: {B[15:0],16'h0}
  - 11..15 produce 0
- R-type (opcode 0):
  - regwrite=1, imm_reg=0, memread=0, memwrite=0.
  - funct mapping: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - Any other funct: regwrite=0, alu_op=ADD.
- I-type, all with imm_reg=1:
  - 0x08 addi ADD, 0x0A slti SLT, 0x0C andi AND, 0x0D ori OR, 0x0E xori XOR, 0x0F lui LUI; all with regwrite=1.
  - 0x23 lw: ADD, regwrite=1, memread=1.
  - 0x2B sw: ADD, memwrite=1, regwrite=0.
- 0x04 beq / 0x05 bne: SUB, imm_reg=0, no writes; zero is the branch condition.
- Unknown opcodes (including 0x02 j): all enables 0, alu_op=ADD, imm_reg=0.
- Operands:
  - A = reg_rs.
  - B = imm_reg ? sign_extend(imm) : reg_rt. The immediate is always sign-extended, logical ops included.
- Arithmetic wraps modulo 2^32; no overflow flag.
- Memory word index is alu_result[AW+1:2]:
  - bits [1:0] ignored (no misalignment fault)
  - upper bits ignored (address wraps modulo DEPTH).
- Reads are combinational: read_data follows the address the same cycle.
- Writes: on posedge clk when memwrite=1, mem[index] <= reg_rt. The new value is visible on read_data after the edge.
- Reset:
  - rst high clears every word to 0 immediately and blocks writes while asserted.
  - Combinational outputs are unaffected by rst.
  - Release mid-cycle: the next posedge with memwrite writes normally.

Optional Feature:
- MEM_BOUNDS_CHECK_EN. When defined:
  - adds output mem_err (1 bit), high when memread or memwrite is active and alu_result[31:AW+2] != 0 or alu_result[1:0] != 0.
  - a flagged write is suppressed; a flagged read returns 0.
- When undefined: no mem_err port; addresses wrap as above.

Test Plan:
- instruction=32'h000A5B22 -> opcode 0, rs 0, rt 10, rd 11, shamt 12, funct 0x22, regwrite 1, memwrite 0, memread 0, alu_op 1, imm_reg 0.
- addi (opcode 0x08, imm 0xFFFF), reg_rs=5 -> alu_result 4, write_data 4, zero 0.
- sw with reg_rs=0, imm 8, reg_rt=0xDEADBEEF, one clk; then lw same address -> read_data and write_data 0xDEADBEEF.
- beq with reg_rs=reg_rt=7 -> zero 1, regwrite 0, memwrite 0. SLT with reg_rs=-1, reg_rt=1 -> alu_result 1.
- Assert rst asynchronously after writing mem[2] -> read_data at address 8 becomes 0 without a clock edge; writes blocked while rst is high.
- Unknown opcode 0x3F with reg values set -> all enables 0. Address 4*DEPTH+8 aliases word 2; with MEM_BOUNDS_CHECK_EN, mem_err=1 and the write is suppressed.
